// File: rtl/gpio_controller_n.sv
// gpio_controller_n: memory-mapped GPIO with WIDTH configurable-direction
// pins, a synchronised input path, atomic output set/clear, and per-pin
// rising/falling edge capture into a write-1-to-clear STATUS register.
//
// Bus protocol: a single-cycle, zero-wait-state access. An access is
// presented when Adr_in falls inside the 32-byte window. A write is accepted
// at the clk edge that samples hit & MemWrite_in. Read data is
// combinational from registered state in the same cycle. There is no
// valid/ready handshake because the peripheral is always ready.
module gpio_controller_n #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Adr_in,
  input  logic             MemWrite_in,
  input  logic [31:0]      Data_in,
  output logic [31:0]      Data_out,
  input  logic [WIDTH-1:0] gpio_port_in,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] OFF_OUT     = 3'd0;
  localparam logic [2:0] OFF_DIR     = 3'd1;
  localparam logic [2:0] OFF_IN      = 3'd2;
  localparam logic [2:0] OFF_RISE_EN = 3'd3;
  localparam logic [2:0] OFF_FALL_EN = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;
  localparam logic [2:0] OFF_OUT_SET = 3'd6;
  localparam logic [2:0] OFF_OUT_CLR = 3'd7;

  logic             hit;
  logic [2:0]       offset;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_data;

  // Byte lanes and upper write bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{Adr_in[1:0], Data_in};

  assign hit    = (Adr_in[31:5] == BASE_ADDR[31:5]);
  assign offset = Adr_in[4:2];
  assign wr_en  = hit & MemWrite_in;
  assign wdata  = Data_in[WIDTH-1:0];

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q & rise_en_q;
  assign fall = ~sync & prev_q & fall_en_q;
  assign clr  = (wr_en && offset == OFF_STATUS) ? wdata : '0;

  assign gpio_port_out = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = |status_q;
  assign Data_out      = rd_data;

  // Input synchroniser chain followed by the one-cycle-delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_port_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
    end
  end

  // Register writes and STATUS update; a same-cycle edge beats a W1C clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      if (wr_en) begin
        case (offset)
          OFF_OUT:     out_q     <= wdata;
          OFF_DIR:     dir_q     <= wdata;
          OFF_RISE_EN: rise_en_q <= wdata;
          OFF_FALL_EN: fall_en_q <= wdata;
          OFF_OUT_SET: out_q     <= out_q | wdata;
          OFF_OUT_CLR: out_q     <= out_q & ~wdata;
          default:     ;
        endcase
      end
      status_q <= (status_q & ~clr) | rise | fall;
    end
  end

  // Read mux: zero-extended register contents, zero on a miss or write-only offset.
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (offset)
        OFF_OUT:     rd_data[WIDTH-1:0] = out_q;
        OFF_DIR:     rd_data[WIDTH-1:0] = dir_q;
        OFF_IN:      rd_data[WIDTH-1:0] = sync;
        OFF_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
        OFF_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
        OFF_STATUS:  rd_data[WIDTH-1:0] = status_q;
        default:     rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_controller_n.sv
// Testbench for gpio_controller_n: default 8-bit instance plus a 32-bit
// instance at a different base. Drivers push expected values into a queue;
// the monitor pops and compares on every falling clk edge or on demand.
module tb_gpio_controller_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] adr_a, din_a, dout_a;
  logic        we_a;
  logic [7:0]  pins_a, out_a, oe_a;
  logic        irq_a;

  logic [31:0] adr_b, din_b, dout_b;
  logic        we_b;
  logic [31:0] pins_b, out_b, oe_b;
  logic        irq_b;

  gpio_controller_n dut_a (
    .clk(clk), .rst(rst), .Adr_in(adr_a), .MemWrite_in(we_a), .Data_in(din_a),
    .Data_out(dout_a), .gpio_port_in(pins_a), .gpio_port_out(out_a),
    .gpio_oe(oe_a), .irq(irq_a)
  );

  gpio_controller_n #(.WIDTH(32), .BASE_ADDR(32'h2000_0000), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .Adr_in(adr_b), .MemWrite_in(we_b), .Data_in(din_b),
    .Data_out(dout_b), .gpio_port_in(pins_b), .gpio_port_out(out_b),
    .gpio_oe(oe_b), .irq(irq_b)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  event        chk_ev;

  localparam int S_DOUT_A = 0, S_OUT_A = 1, S_OE_A = 2, S_IRQ_A = 3;
  localparam int S_DOUT_B = 4, S_OE_B = 5, S_OUT_B = 6;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_DOUT_A: return dout_a;
      S_OUT_A:  return {24'h0, out_a};
      S_OE_A:   return {24'h0, oe_a};
      S_IRQ_A:  return {31'h0, irq_a};
      S_DOUT_B: return dout_b;
      S_OE_B:   return oe_b;
      S_OUT_B:  return out_b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drain all pending expectations at each sample point.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        logic [31:0] e, act;
        int          s;
        string       nm;
        e   = exp_q.pop_front();
        s   = sel_q.pop_front();
        nm  = name_q.pop_front();
        act = observe(s);
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got 32'h%08h expected 32'h%08h", nm, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
    adr_a = a; din_a = d; we_a = 1'b1;
    tick();
    we_a = 1'b0;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] e, input string nm);
    adr_a = a;
    expect_v(S_DOUT_A, e, nm);
    tick();
  endtask

  task automatic wr_b(input logic [31:0] a, input logic [31:0] d);
    adr_b = a; din_b = d; we_b = 1'b1;
    tick();
    we_b = 1'b0;
  endtask

  task automatic rd_b(input logic [31:0] a, input logic [31:0] e, input string nm);
    adr_b = a;
    expect_v(S_DOUT_B, e, nm);
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    adr_a = 32'h0; din_a = 32'h0; we_a = 1'b0; pins_a = 8'hFF;
    adr_b = 32'h0; din_b = 32'h0; we_b = 1'b0; pins_b = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state, and synchroniser latency for pins already high.
    expect_v(S_OUT_A, 32'h0, "rst_port_out");
    expect_v(S_OE_A,  32'h0, "rst_oe");
    expect_v(S_IRQ_A, 32'h0, "rst_irq");
    rd_a(32'h1001_0000, 32'h0,  "rst_out_reg");
    rd_a(32'h1001_0008, 32'h0,  "in_after_1_edge");
    rd_a(32'h1001_0008, 32'hFF, "in_after_2_edges");
    expect_v(S_IRQ_A, 32'h0, "no_capture_at_release");
    rd_a(32'h1001_0014, 32'h0,  "rst_status");
    rd_a(32'h1001_0004, 32'h0,  "rst_dir_reg");

    // OUT, OUT_SET, OUT_CLR and write-only reads.
    wr_a(32'h1001_0000, 32'h0F); expect_v(S_OUT_A, 32'h0F, "out_write");
    wr_a(32'h1001_0018, 32'hA0); expect_v(S_OUT_A, 32'hAF, "out_set");
    wr_a(32'h1001_001C, 32'h05); expect_v(S_OUT_A, 32'hAA, "out_clr");
    rd_a(32'h1001_0018, 32'h0,  "out_set_reads_0");
    rd_a(32'h1001_001C, 32'h0,  "out_clr_reads_0");
    rd_a(32'h1001_0003, 32'hAA, "out_read_low_bits_ignored");
    wr_a(32'h1001_0004, 32'hFFFF_FF3C); expect_v(S_OE_A, 32'h3C, "dir_write_upper_ignored");
    rd_a(32'h1001_0004, 32'h3C, "dir_read");

    // Edge capture: disabled edge, then rise on pin0 and fall on pin7.
    pins_a = 8'hFE; idle(3);
    expect_v(S_IRQ_A, 32'h0, "fall_not_enabled");
    wr_a(32'h1001_000C, 32'h01);
    wr_a(32'h1001_0010, 32'h80);
    pins_a = 8'hFF;
    idle(2); expect_v(S_IRQ_A, 32'h0, "irq_after_2_edges");
    idle(1); expect_v(S_IRQ_A, 32'h1, "irq_after_3_edges");
    rd_a(32'h1001_0014, 32'h01, "status_rise_pin0");
    pins_a = 8'h7F; idle(3);
    rd_a(32'h1001_0014, 32'h81, "status_rise_and_fall");
    wr_a(32'h1001_0014, 32'h01); expect_v(S_IRQ_A, 32'h1, "irq_after_partial_clear");
    rd_a(32'h1001_0014, 32'h80, "status_after_clear_bit0");
    wr_a(32'h1001_000C, 32'h00);
    rd_a(32'h1001_0014, 32'h80, "status_kept_on_en_change");
    wr_a(32'h1001_0014, 32'h80); expect_v(S_IRQ_A, 32'h0, "irq_after_full_clear");
    rd_a(32'h1001_0014, 32'h0,  "status_cleared");

    // Edge and W1C on the same bit in the same cycle: set wins.
    pins_a = 8'h7D; idle(3);
    wr_a(32'h1001_000C, 32'h02);
    pins_a = 8'h7F;
    idle(2);
    wr_a(32'h1001_0014, 32'h02);
    expect_v(S_IRQ_A, 32'h1, "collide_irq");
    rd_a(32'h1001_0014, 32'h02, "collide_set_wins");
    wr_a(32'h1001_0014, 32'h02); expect_v(S_IRQ_A, 32'h0, "collide_later_clear");

    // Asynchronous reset pulse between edges with STATUS and OUT nonzero.
    pins_a = 8'h7D; idle(3);
    pins_a = 8'h7F; idle(3);
    rd_a(32'h1001_0014, 32'h02, "pre_rst_status");
    adr_a = 32'h1001_0000;
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    expect_v(S_DOUT_A, 32'h0, "async_rst_out_reg");
    expect_v(S_OUT_A,  32'h0, "async_rst_port_out");
    expect_v(S_OE_A,   32'h0, "async_rst_oe");
    expect_v(S_IRQ_A,  32'h0, "async_rst_irq");
    -> chk_ev;
    tick();
    idle(3);
    expect_v(S_IRQ_A, 32'h0, "irq_after_rst_release");
    rd_a(32'h1001_0014, 32'h0,  "status_after_rst");
    rd_a(32'h1001_0008, 32'h7F, "in_after_rst");

    // 32-bit instance at 0x2000_0000: DIR write and an out-of-window access.
    wr_b(32'h2000_0004, 32'hFFFF_0000); expect_v(S_OE_B, 32'hFFFF_0000, "b_dir_oe");
    rd_b(32'h2000_0004, 32'hFFFF_0000, "b_dir_read");
    adr_b = 32'h2000_0020; din_b = 32'hFFFF_FFFF; we_b = 1'b1;
    expect_v(S_DOUT_B, 32'h0, "b_miss_read_zero");
    tick();
    we_b = 1'b0;
    expect_v(S_OE_B,  32'hFFFF_0000, "b_miss_dir_kept");
    expect_v(S_OUT_B, 32'h0,         "b_miss_out_kept");
    rd_b(32'h2000_0000, 32'h0, "b_out_read");

    // Let the monitor drain, then report.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_controller_n.md
# gpio_controller_n

Parametrised memory-mapped GPIO peripheral, next generation of the SoC's 8-bit switch/LED GPIO. Provides WIDTH configurable-direction pins, a synchronised input path, atomic set/clear of outputs, and per-pin rising/falling-edge interrupt capture with write-1-to-clear status. It sits on the core's data bus beside ROM and RAM and is selected by the peripherals control unit's address decode.

## Interface
- WIDTH, 8: number of pins, legal range 1..32.
- BASE_ADDR, 32'h1001_0000: base of the 32-byte register window. Bits [4:0] must be 0.
- SYNC_STAGES, 2: flops in the input synchroniser, minimum 2.
- clk  in  1  system clock. Everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Clears all state.
- Adr_in  in  32  byte address from the core.
- MemWrite_in  in  1  write strobe, qualified by an address hit.
- Data_in  in  32  write data.
- Data_out  out  32  read data. Combinational from registered state.
- gpio_port_in  in  WIDTH  pin inputs, asynchronous to clk.
- gpio_port_out  out  WIDTH  pin output values.
- gpio_oe  out  WIDTH  per-pin output enable, 1 = drive.
- irq  out  1  level interrupt.

## Operation
Address decode:
- hit = (Adr_in[31:5] == BASE_ADDR[31:5]).
- Register offset is Adr_in[4:2]. Adr_in[1:0] are ignored.
- Only whole-word accesses are supported.

Register map (WIDTH-bit registers, read bits [31:WIDTH] as 0, write bits [31:WIDTH] ignored):
- 0x00 OUT, RW: drives gpio_port_out.
- 0x04 DIR, RW: drives gpio_oe.
- 0x08 IN, RO: synchronised pins. Reflects pin state regardless of DIR.
- 0x0C RISE_EN, RW: per-pin rising-edge capture enable.
- 0x10 FALL_EN, RW: per-pin falling-edge capture enable.
- 0x14 STATUS, R/W1C: captured edges. Writing 1 clears a bit; writing 0 has no effect.
- 0x18 OUT_SET, WO: OUT <= OUT | Data_in. Reads 0.
- 0x1C OUT_CLR, WO: OUT <= OUT & ~Data_in. Reads 0.

Read path:
- Data_out = 0 when there is no hit.
- Reads have no side effects.

Input path:
- gpio_port_in passes through a SYNC_STAGES flop chain to give sync.
- A further flop holds prev = sync delayed by one cycle.
- rise = sync & ~prev & RISE_EN.
- fall = ~sync & prev & FALL_EN.

Status update, every cycle:
- STATUS <= (STATUS & ~clr) | rise | fall.
- clr = Data_in[WIDTH-1:0] when hit, MemWrite_in and offset 0x14; otherwise 0.
- If an edge and a clear hit the same bit in the same cycle, set wins.

Interrupt:
- irq = |STATUS. No extra register stage.
- Changing RISE_EN or FALL_EN never modifies STATUS.

## Timing
- Reset values are 0 for OUT, DIR, RISE_EN, FALL_EN, STATUS, the sync chain and prev. Therefore gpio_port_out=0, gpio_oe=0 (all pins inputs) and irq=0.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- Writes take effect at the clk edge where hit & MemWrite_in are sampled. Outputs reflect the new value right after that edge, i.e. 1-cycle latency.
- Read data is valid in the same cycle as Adr_in, with zero wait states.
- Pin change to IN: visible after SYNC_STAGES edges.
- Pin change to STATUS/irq: visible after SYNC_STAGES+1 edges.
- A pulse shorter than one clk period may be missed. This is by design.
- Pins high at reset release produce a rise after SYNC_STAGES edges. It is captured only if RISE_EN is already set, so with the reset enables it is not captured.
- Back-to-back accesses are allowed every cycle. One write per cycle, so OUT_SET and OUT_CLR can never collide.

## Test plan
- Reset with gpio_port_in=8'hFF, then read 0x00, 0x04, 0x14 → all 0, gpio_oe=0, irq=0. After 2 cycles, read 0x08 → 32'h0000_00FF.
- Write OUT=8'h0F, then OUT_SET 8'hA0, then OUT_CLR 8'h05 → gpio_port_out sequence 0F, AF, AA, each on the edge after the write. Reads of 0x18 and 0x1C → 0.
- RISE_EN=8'h01, FALL_EN=8'h80. Pin0 goes 0→1 at cycle t, then pin7 goes 1→0 → STATUS bit0 set at edge t+3, irq=1. Later STATUS=8'h81. Write 0x14=8'h01 → STATUS=8'h80, irq stays 1. Write 8'h80 → irq=0.
- Pin1 rise reaches the edge detector in the same cycle as a W1C write of 8'h02, with RISE_EN[1]=1 → STATUS[1] remains 1.
- WIDTH=32, BASE_ADDR=32'h2000_0000 variant: write DIR=32'hFFFF_0000 at 0x2000_0004 → gpio_oe matches. An access at 0x2000_0020 → no hit, Data_out=0, no register changes.
- Assert rst for 1 ns between clk edges while STATUS≠0 and OUT≠0 → all outputs 0 immediately.
